// File: rtl/crc_arbiter_if.sv
// ----------------------------------------------------------------------------
// crc_arbiter_if
// Bundles every non-clock signal of crc_arbiter:
//   cfg_*  : per-channel CRC configuration write port
//   req_*  : per-channel packet beat streams (valid/last/data, ready back)
//   eng_*  : configuration, data and result connections to the CRC engine
//   res_*  : tagged CRC result handshake
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (sources, engine, result sink)
// ----------------------------------------------------------------------------
interface crc_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                         cfg_wr;
  logic [CH_W-1:0]              cfg_ch;
  logic [CRC_WIDTH:0]           cfg_poly;
  logic [CRC_WIDTH-1:0]         cfg_init;
  logic [CRC_WIDTH-1:0]         cfg_xorout;
  logic                         cfg_data_rev;
  logic                         cfg_crc_rev;

  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_last;
  logic [NUM_CH*DATA_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]            req_ready;

  logic                         eng_clear;
  logic [CRC_WIDTH-1:0]         eng_init;
  logic [CRC_WIDTH:0]           eng_poly;
  logic                         eng_data_rev;
  logic                         eng_crc_rev;
  logic [CRC_WIDTH-1:0]         eng_xorout;
  logic [DATA_WIDTH-1:0]        eng_data;
  logic                         eng_data_valid;
  logic [CRC_WIDTH-1:0]         eng_crc;

  logic                         res_valid;
  logic                         res_ready;
  logic [CRC_WIDTH-1:0]         res_crc;
  logic [CH_W-1:0]              res_ch;
  logic                         res_err;

  modport slave (
    input  cfg_wr, cfg_ch, cfg_poly, cfg_init, cfg_xorout, cfg_data_rev, cfg_crc_rev,
    input  req_valid, req_last, req_data,
    output req_ready,
    output eng_clear, eng_init, eng_poly, eng_data_rev, eng_crc_rev, eng_xorout,
    output eng_data, eng_data_valid,
    input  eng_crc,
    output res_valid, res_crc, res_ch, res_err,
    input  res_ready
  );

  modport master (
    output cfg_wr, cfg_ch, cfg_poly, cfg_init, cfg_xorout, cfg_data_rev, cfg_crc_rev,
    output req_valid, req_last, req_data,
    input  req_ready,
    input  eng_clear, eng_init, eng_poly, eng_data_rev, eng_crc_rev, eng_xorout,
    input  eng_data, eng_data_valid,
    output eng_crc,
    input  res_valid, res_crc, res_ch, res_err,
    output res_ready
  );
endinterface

// File: rtl/crc_arbiter.sv
// ----------------------------------------------------------------------------
// crc_arbiter
// Round-robin packet arbiter that time-shares one configurable CRC engine
// among NUM_CH requesters. Each grant loads that channel's stored CRC
// configuration onto the engine, clears the engine, streams the packet
// through and returns the final CRC tagged with the channel index.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : crc_arbiter_if.slave (cfg_*, req_*, eng_*, res_* groups)
// Optional build macro:
//   CRC_ARB_TIMEOUT_EN : abort a packet after TIMEOUT_CYCLES consecutive
//                        stalled STREAM cycles and report it with res_err=1.
// ----------------------------------------------------------------------------
module crc_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int CRC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  crc_arbiter_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [CH_W-1:0]       rr_r, grant_r, pick_ch_s;
  logic                  pick_found_s;
  logic                  grant_valid_s, grant_last_s;
  logic [DATA_WIDTH-1:0] grant_data_s;
  logic                  abort_s;
  logic                  err_r;

  logic [CRC_WIDTH:0]    bank_poly_r   [NUM_CH];
  logic [CRC_WIDTH-1:0]  bank_init_r   [NUM_CH];
  logic [CRC_WIDTH-1:0]  bank_xorout_r [NUM_CH];
  logic                  bank_drev_r   [NUM_CH];
  logic                  bank_crev_r   [NUM_CH];

  logic [CRC_WIDTH:0]    act_poly_r;
  logic [CRC_WIDTH-1:0]  act_init_r;
  logic [CRC_WIDTH-1:0]  act_xorout_r;
  logic                  act_drev_r;
  logic                  act_crev_r;

  assign grant_valid_s = bus.req_valid[grant_r];
  assign grant_last_s  = bus.req_last[grant_r];
  assign grant_data_s  = bus.req_data[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin pick: first valid channel at or after rr_r, wrapping upward.
  always_comb begin
    int scan_idx;
    scan_idx     = 0;
    pick_found_s = 1'b0;
    pick_ch_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = (int'(rr_r) + i) % NUM_CH;
      if (!pick_found_s && bus.req_valid[scan_idx]) begin
        pick_found_s = 1'b1;
        pick_ch_s    = CH_W'(scan_idx);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

`ifdef CRC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt_r;

  // Stall counter: restarts on every accepted beat and outside STREAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= '0;
    end else if ((state_r != STREAM) || grant_valid_s) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_r + TO_W'(1);
    end
  end

  // The cycle that would make the TIMEOUT_CYCLES-th consecutive stall.
  assign abort_s = (state_r == STREAM) && !grant_valid_s &&
                   (stall_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No stall limit in this build; the parameter only matters with the timeout.
  assign abort_s = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) state_s = CLEAR;
        else              state_s = IDLE;
      end
      CLEAR: state_s = STREAM;
      STREAM: begin
        if (grant_valid_s && grant_last_s) state_s = RESULT;
        else if (abort_s)                  state_s = RESULT;
        else                               state_s = STREAM;
      end
      RESULT: begin
        if (bus.res_ready) state_s = IDLE;
        else               state_s = RESULT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Grant, rr pointer, active configuration and abort flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_r         <= '0;
      grant_r      <= '0;
      err_r        <= 1'b0;
      act_poly_r   <= '0;
      act_init_r   <= '0;
      act_xorout_r <= '0;
      act_drev_r   <= 1'b0;
      act_crev_r   <= 1'b0;
    end else if ((state_r == IDLE) && pick_found_s) begin
      grant_r      <= pick_ch_s;
      err_r        <= 1'b0;
      act_poly_r   <= bank_poly_r[pick_ch_s];
      act_init_r   <= bank_init_r[pick_ch_s];
      act_xorout_r <= bank_xorout_r[pick_ch_s];
      act_drev_r   <= bank_drev_r[pick_ch_s];
      act_crev_r   <= bank_crev_r[pick_ch_s];
    end else if ((state_r == STREAM) && abort_s) begin
      err_r <= 1'b1;
    end else if ((state_r == RESULT) && bus.res_ready) begin
      rr_r <= CH_W'((int'(grant_r) + 1) % NUM_CH);
    end else begin
      rr_r <= rr_r;
    end
  end

  // Per-channel configuration bank; out-of-range channel writes are dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank_poly_r[i]   <= '0;
        bank_init_r[i]   <= '0;
        bank_xorout_r[i] <= '0;
        bank_drev_r[i]   <= 1'b0;
        bank_crev_r[i]   <= 1'b0;
      end
    end else if (bus.cfg_wr && (int'(bus.cfg_ch) < NUM_CH)) begin
      bank_poly_r[bus.cfg_ch]   <= bus.cfg_poly;
      bank_init_r[bus.cfg_ch]   <= bus.cfg_init;
      bank_xorout_r[bus.cfg_ch] <= bus.cfg_xorout;
      bank_drev_r[bus.cfg_ch]   <= bus.cfg_data_rev;
      bank_crev_r[bus.cfg_ch]   <= bus.cfg_crc_rev;
    end else begin
      bank_drev_r[0] <= bank_drev_r[0];
    end
  end

  assign bus.eng_poly     = act_poly_r;
  assign bus.eng_init     = act_init_r;
  assign bus.eng_xorout   = act_xorout_r;
  assign bus.eng_data_rev = act_drev_r;
  assign bus.eng_crc_rev  = act_crev_r;

  // State-decoded handshake and engine data outputs.
  always_comb begin
    bus.req_ready      = '0;
    bus.eng_clear      = 1'b0;
    bus.eng_data       = '0;
    bus.eng_data_valid = 1'b0;
    bus.res_valid      = 1'b0;
    bus.res_crc        = '0;
    bus.res_ch         = '0;
    bus.res_err        = 1'b0;
    case (state_r)
      IDLE:  bus.req_ready = '0;
      CLEAR: bus.eng_clear = 1'b1;
      STREAM: begin
        bus.req_ready[grant_r] = 1'b1;
        bus.eng_data           = grant_data_s;
        bus.eng_data_valid     = grant_valid_s;
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        bus.res_crc   = bus.eng_crc;
        bus.res_ch    = grant_r;
        bus.res_err   = err_r;
      end
      default: bus.req_ready = '0;
    endcase
  end
endmodule

// File: tb/tb_crc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_crc_arbiter
// Drives crc_arbiter with directed and randomized packet traffic, closes the
// loop through a behavioural CRC engine, and checks results against a
// packet-level reference (whole-packet CRC plus round-robin service order).
// ----------------------------------------------------------------------------
module tb_crc_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int CW     = 32;
  localparam int TO     = 16;
  localparam int CH_W   = 2;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_mis;

  crc_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CRC_WIDTH(CW)) bus ();

  crc_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CRC_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC width is the position of the polynomial's top set bit.
  function automatic int crc_w(input logic [CW:0] poly);
    int w;
    w = 0;
    for (int i = 0; i <= CW; i++) if (poly[i]) w = i;
    return w;
  endfunction

  function automatic logic [CW-1:0] crc_mask(input int w);
    logic [CW-1:0] m;
    m = (w >= CW) ? {CW{1'b1}} : ((CW'(1) << w) - CW'(1));
    return m;
  endfunction

  // Bitwise MSB-first division over one beat (LSB-first when data reflected).
  function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] st, input logic [DW-1:0] d,
                                             input logic [CW:0] poly, input logic drev);
    int w;
    logic [CW-1:0] m;
    logic b, fb;
    w = crc_w(poly);
    if (w == 0) return '0;
    m = crc_mask(w);
    for (int i = 0; i < DW; i++) begin
      b  = drev ? d[i] : d[DW-1-i];
      fb = st[w-1] ^ b;
      st = (st << 1) & m;
      if (fb) st = st ^ (poly[CW-1:0] & m);
    end
    return st;
  endfunction

  function automatic logic [CW-1:0] crc_fin(input logic [CW-1:0] st, input logic [CW:0] poly,
                                            input logic crev, input logic [CW-1:0] xo);
    int w;
    logic [CW-1:0] r;
    w = crc_w(poly);
    r = st;
    if (crev) begin
      r = '0;
      for (int i = 0; i < w; i++) r[i] = st[w-1-i];
    end
    return (r ^ xo) & crc_mask(w);
  endfunction

  // Behavioural CRC engine driven by the arbiter's eng_* outputs.
  logic [CW-1:0] eng_st;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) eng_st <= '0;
    else if (bus.eng_clear) eng_st <= bus.eng_init;
    else if (bus.eng_data_valid) eng_st <= crc_step(eng_st, bus.eng_data, bus.eng_poly, bus.eng_data_rev);
  end
  assign bus.eng_crc = crc_fin(eng_st, bus.eng_poly, bus.eng_crc_rev, bus.eng_xorout);

  // Reference state: configuration bank, pending packets, expected results.
  logic [CW:0]   m_poly [NUM_CH];
  logic [CW-1:0] m_init [NUM_CH];
  logic [CW-1:0] m_xo   [NUM_CH];
  logic          m_drev [NUM_CH];
  logic          m_crev [NUM_CH];
  int            m_rr;
  logic [7:0]    q_data [NUM_CH][$];
  int            q_len  [NUM_CH][$];
  logic [CW-1:0] p_crc  [NUM_CH][$];
  int            bpos   [NUM_CH];
  int            e_ch[$];
  logic [CW-1:0] e_crc[$];
  logic          e_err[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input int ch, input logic [CW-1:0] crc, input logic err);
    e_ch.push_back(ch);
    e_crc.push_back(crc);
    e_err.push_back(err);
    m_rr = (ch + 1) % NUM_CH;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_CH; k++) begin
      m_poly[k] = '0; m_init[k] = '0; m_xo[k] = '0; m_drev[k] = 1'b0; m_crev[k] = 1'b0;
      q_data[k].delete(); q_len[k].delete(); p_crc[k].delete(); bpos[k] = 0;
    end
    e_ch.delete(); e_crc.delete(); e_err.delete();
    m_rr = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_poly = '0; bus.cfg_init = '0;
    bus.cfg_xorout = '0; bus.cfg_data_rev = 1'b0; bus.cfg_crc_rev = 1'b0;
    bus.req_valid = 4'hF; bus.req_last = 4'h0; bus.req_data = 32'hA5A5_A5A5;
    bus.res_ready = 1'b1;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_eng_cfg", 64'(|{bus.eng_init, bus.eng_poly, bus.eng_xorout,
                               bus.eng_data_rev, bus.eng_crc_rev}), 64'd0);
    check("rst_eng_data", 64'({bus.eng_clear, bus.eng_data_valid, bus.eng_data}), 64'd0);
    check("rst_res", 64'({bus.res_valid, bus.res_err, bus.res_ch, bus.res_crc}), 64'd0);
    bus.req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_model();
  endtask

  task automatic cfg_write(input int ch, input logic [CW:0] poly, input logic [CW-1:0] init,
                           input logic [CW-1:0] xo, input logic drev, input logic crev);
    bus.cfg_wr = 1'b1; bus.cfg_ch = CH_W'(ch); bus.cfg_poly = poly; bus.cfg_init = init;
    bus.cfg_xorout = xo; bus.cfg_data_rev = drev; bus.cfg_crc_rev = crev;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
    m_poly[ch] = poly; m_init[ch] = init; m_xo[ch] = xo; m_drev[ch] = drev; m_crev[ch] = crev;
  endtask

  task automatic cfg_crc32(input int ch);
    cfg_write(ch, 33'h1_04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic rand_cfg(input int ch);
    int w;
    logic [CW-1:0] msk;
    logic [CW:0] p;
    w   = 8 << $urandom_range(2);
    msk = crc_mask(w);
    p   = ((CW+1)'(1) << w) | {1'b0, CW'($urandom) & msk} | (CW+1)'(1);
    cfg_write(ch, p, CW'($urandom) & msk, CW'($urandom) & msk, 1'($urandom), 1'($urandom));
  endtask

  task automatic add_str(input int ch, input string s);
    logic [CW-1:0] st;
    logic [7:0] b;
    st = m_init[ch];
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      q_data[ch].push_back(b);
      st = crc_step(st, b, m_poly[ch], m_drev[ch]);
    end
    q_len[ch].push_back(s.len());
    p_crc[ch].push_back(crc_fin(st, m_poly[ch], m_crev[ch], m_xo[ch]));
  endtask

  task automatic add_rand(input int ch, input int len);
    logic [CW-1:0] st;
    logic [7:0] b;
    st = m_init[ch];
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      q_data[ch].push_back(b);
      st = crc_step(st, b, m_poly[ch], m_drev[ch]);
    end
    q_len[ch].push_back(len);
    p_crc[ch].push_back(crc_fin(st, m_poly[ch], m_crev[ch], m_xo[ch]));
  endtask

  // Service order: next packet comes from the first pending channel at/after rr.
  task automatic predict_order();
    int idx[NUM_CH];
    int left;
    left = 0;
    for (int k = 0; k < NUM_CH; k++) begin idx[k] = 0; left += p_crc[k].size(); end
    while (left > 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int k;
        k = (m_rr + i) % NUM_CH;
        if (idx[k] < p_crc[k].size()) begin
          exp_push(k, p_crc[k][idx[k]], 1'b0);
          idx[k]++;
          left--;
          break;
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) p_crc[k].delete();
  endtask

  // Cycle loop: present queued beats, consume on ready, check each result cycle.
  task automatic run_traffic(input int max_cycles, input int stop_beats, input int stall_cycles,
                             input bit gaps, input bit rnd_ready);
    logic [NUM_CH-1:0]    rv, rl;
    logic [NUM_CH*DW-1:0] rd;
    int beats, stall_left, pend;
    bit prev_hs, done;
    beats = 0; stall_left = stall_cycles; prev_hs = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (q_len[k].size() > 0) begin
          rv[k] = (bpos[k] == 0) || !gaps || ($urandom_range(3) != 0);
          rl[k] = (bpos[k] == q_len[k][0] - 1);
          rd[k*DW +: DW] = q_data[k][0];
        end else begin
          rv[k] = 1'b0;
          rl[k] = 1'($urandom);
          rd[k*DW +: DW] = 8'($urandom);
        end
      end
      bus.req_valid = rv; bus.req_last = rl; bus.req_data = rd;
      bus.res_ready = (stall_left > 0) ? 1'b0 : (rnd_ready ? 1'($urandom_range(1)) : 1'b1);
      #1;
      if (prev_hs) check("res_after_accept", 64'(bus.res_valid), 64'd0);
      prev_hs = 1'b0;
      check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      if (bus.res_valid) begin
        check("res_no_ready", 64'(bus.req_ready), 64'd0);
        if (e_ch.size() == 0) begin
          check("res_unexpected", 64'(bus.res_valid), 64'd0);
        end else begin
          check("res_ch", 64'(bus.res_ch), 64'(e_ch[0]));
          check("res_crc", 64'(bus.res_crc), 64'(e_crc[0]));
          check("res_err", 64'(bus.res_err), 64'(e_err[0]));
          if (bus.res_ready) begin
            void'(e_ch.pop_front()); void'(e_crc.pop_front()); void'(e_err.pop_front());
            prev_hs = 1'b1;
          end else if (stall_left > 0) begin
            stall_left--;
          end
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.req_ready[k] && rv[k]) begin
          void'(q_data[k].pop_front());
          bpos[k]++;
          beats++;
          if (bpos[k] == q_len[k][0]) begin
            void'(q_len[k].pop_front());
            bpos[k] = 0;
          end
        end
      end
      if ((stop_beats > 0) && (beats >= stop_beats)) break;
      pend = e_ch.size();
      for (int k = 0; k < NUM_CH; k++) pend += q_len[k].size();
      if (pend == 0) begin done = 1'b1; break; end
      @(negedge clk);
    end
    if (stop_beats == 0) begin
      check("traffic_drain", 64'(e_ch.size()), 64'd0);
      if (done) @(negedge clk);
    end
  endtask

  initial begin
    logic [CW-1:0] st;
    int cnt;
    n_cmp = 0;
    n_mis = 0;
    resetn = 1'b0;
    do_reset();

    // Known-answer vectors: CRC-32 on ch0, CRC-16/CCITT-FALSE on ch2 (with gaps).
    cfg_crc32(0);
    cfg_write(2, 33'h0_0001_1021, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0);
    add_str(0, "123456789"); exp_push(0, 32'hCBF4_3926, 1'b0);
    run_traffic(200, 0, 0, 1'b0, 1'b0);
    add_str(2, "123456789"); exp_push(2, 32'h0000_29B1, 1'b0);
    run_traffic(400, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < NUM_CH; k++) p_crc[k].delete();

    // Result back-pressure: res_ready low for 5 RESULT cycles.
    add_str(0, "123456789"); exp_push(0, 32'hCBF4_3926, 1'b0);
    run_traffic(200, 0, 5, 1'b0, 1'b0);
    for (int k = 0; k < NUM_CH; k++) p_crc[k].delete();

    // Fairness: all four channels continuously valid, 2-beat packets.
    do_reset();
    for (int k = 0; k < NUM_CH; k++) rand_cfg(k);
    for (int r = 0; r < 2; r++) for (int k = 0; k < NUM_CH; k++) add_rand(k, 2);
    for (int r = 0; r < 2; r++) for (int k = 0; k < NUM_CH; k++) exp_push(k, p_crc[k][r], 1'b0);
    for (int k = 0; k < NUM_CH; k++) p_crc[k].delete();
    run_traffic(400, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a ch1 packet, then resend it.
    cfg_crc32(1);
    add_str(1, "123456789");
    run_traffic(200, 4, 0, 1'b0, 1'b1);
    do_reset();
    cfg_crc32(1);
    add_str(1, "123456789"); exp_push(1, 32'hCBF4_3926, 1'b0);
    for (int k = 0; k < NUM_CH; k++) p_crc[k].delete();
    run_traffic(200, 0, 0, 1'b0, 1'b0);

    // Randomized configurations, packet mixes, gaps and result back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NUM_CH; k++) rand_cfg(k);
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(3) != 0)
          for (int p = 0; p < int'($urandom_range(3, 1)); p++) add_rand(k, $urandom_range(5, 1));
      predict_order();
      run_traffic(3000, 0, 0, 1'b1, 1'b1);
    end

`ifdef CRC_ARB_TIMEOUT_EN
    // Stalled ch3 packet is aborted after TO idle cycles; ch0 is served next.
    do_reset();
    cfg_crc32(0);
    cfg_crc32(3);
    bus.req_valid = 4'b1000; bus.req_last = 4'b0000; bus.req_data = {8'h31, 24'h0};
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.req_ready[3]) break;
      @(negedge clk);
    end
    check("to_grant3", 64'(bus.req_ready), 64'h8);
    @(negedge clk);
    bus.req_valid = 4'b0001; bus.req_last = 4'b0001; bus.req_data = {24'h0, 8'h32};
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (bus.res_valid) break;
      cnt++;
      @(negedge clk);
    end
    st = crc_step(32'hFFFF_FFFF, 8'h31, 33'h1_04C1_1DB7, 1'b1);
    check("to_cycles", 64'(cnt), 64'd16);
    check("to_err", 64'(bus.res_err), 64'd1);
    check("to_ch", 64'(bus.res_ch), 64'd3);
    check("to_crc", 64'(bus.res_crc), 64'(crc_fin(st, 33'h1_04C1_1DB7, 1'b1, 32'hFFFF_FFFF)));
    bus.res_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.req_ready != '0) break;
      @(negedge clk);
    end
    check("to_next_grant", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.res_valid) break;
      @(negedge clk);
    end
    st = crc_step(32'hFFFF_FFFF, 8'h32, 33'h1_04C1_1DB7, 1'b1);
    check("to_next_ch", 64'(bus.res_ch), 64'd0);
    check("to_next_err", 64'(bus.res_err), 64'd0);
    check("to_next_crc", 64'(bus.res_crc), 64'(crc_fin(st, 33'h1_04C1_1DB7, 1'b1, 32'hFFFF_FFFF)));
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/crc_arbiter.md
Name: crc_arbiter

Overview:
- Packet-level round-robin arbiter and sequencer that shares one dynamically configurable CRC engine among NUM_CH requesters.
- Holds a per-channel CRC configuration bank: polynomial, init, xorout, data/CRC reverse flags.
- On each grant, the block loads the granted channel's configuration, clears the engine, streams the packet through it, and returns the final CRC tagged with the channel index.
- Sits between the packet sources and the CRC engine's configuration, data and result ports.

Parameters:
- NUM_CH, 4, number of requesters (2..16).
- DATA_WIDTH, 32, data beat width; must match the engine.
- CRC_WIDTH, 32, maximum CRC width; must match the engine. The poly bus is CRC_WIDTH+1 bits.
- TIMEOUT_CYCLES, 1024, stall limit in cycles; used only with CRC_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- cfg_wr  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel written; CH_W = max(1, clog2(NUM_CH))
- cfg_poly  in  CRC_WIDTH+1  polynomial, full notation
- cfg_init  in  CRC_WIDTH  init state
- cfg_xorout  in  CRC_WIDTH  output XOR mask
- cfg_data_rev  in  1  data bit-reverse flag
- cfg_crc_rev  in  1  CRC bit-reverse flag
- req_valid  in  NUM_CH  per-channel beat valid
- req_last  in  NUM_CH  per-channel last beat of packet
- req_data  in  NUM_CH*DATA_WIDTH  per-channel data; channel k occupies [k*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_CH  per-channel beat accept
- eng_clear  out  1  engine clear/initialise
- eng_init  out  CRC_WIDTH  to engine init_in
- eng_poly  out  CRC_WIDTH+1  to engine poly_in
- eng_data_rev  out  1  to engine data_reverse
- eng_crc_rev  out  1  to engine crc_reverse
- eng_xorout  out  CRC_WIDTH  to engine xorout_in
- eng_data  out  DATA_WIDTH  to engine data_in
- eng_data_valid  out  1  to engine data_in_valid
- eng_crc  in  CRC_WIDTH  from engine crc_out
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_crc  out  CRC_WIDTH  final CRC
- res_ch  out  CH_W  channel index of the result
- res_err  out  1  packet aborted (timeout)

Behaviour:
- Reset: state IDLE; rr pointer 0; config bank and active config all zero; all outputs 0.
- Config write: when cfg_wr=1, bank[cfg_ch] is updated on that edge. cfg_ch >= NUM_CH is ignored.
- Active config: copied from bank[grant] on the grant edge, then driven on the eng_* configuration outputs until the next grant. A write to the granted channel during a packet takes effect from that channel's next packet.
- FSM states: IDLE, CLEAR, STREAM, RESULT.
- IDLE:
  - If any req_valid is set, grant the first set index at or after the rr pointer, searching upward with wrap.
  - Register grant and active config; next state CLEAR.
  - req_ready stays all 0; the beat is not consumed.
- CLEAR: eng_clear=1 for exactly one cycle; next state STREAM.
- STREAM:
  - req_ready[grant]=1; all other req_ready bits are 0.
  - eng_data = req_data[grant]; eng_data_valid = req_valid[grant].
  - A beat with req_valid[grant] & req_last[grant] moves to RESULT.
  - Valid-low gaps are allowed; the engine holds its state during them.
- RESULT:
  - res_valid=1, res_crc=eng_crc, res_ch=grant, res_err=0.
  - eng_data_valid stays 0, so eng_crc is stable.
  - On res_valid & res_ready: rr pointer = (grant+1) mod NUM_CH, next state IDLE.
- Latency: 1-beat packet accepted at STREAM cycle t gives res_valid at t+1. Minimum packet period is 3 cycles plus the beat count.
- Fairness: a requester that stays valid waits at most NUM_CH-1 packets before it is granted.
- Other req_valid/req_last bits are ignored except during IDLE arbitration.
- Reset mid-packet: immediate return to IDLE with all outputs 0. The partial packet is discarded; the source must restart it.
- NUM_CH=1: always grant channel 0; rr pointer stays 0.

Optional Feature:
- Macro: CRC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted beat and on entry to STREAM, and increments on each STREAM cycle with req_valid[grant]=0.
  - At TIMEOUT_CYCLES the packet is aborted and the FSM enters RESULT with res_err=1 and res_crc=eng_crc (partial).
  - The rr pointer advances normally.
- Not defined: no counter; res_err is tied to 0; a stalled requester holds the engine indefinitely.

Test Plan:
- DATA_WIDTH=8. ch0 configured as CRC-32 (poly 0x104C11DB7, init 0xFFFFFFFF, data_rev=1, crc_rev=1, xorout 0xFFFFFFFF); send "123456789" -> res_crc=0xCBF43926, res_ch=0.
- DATA_WIDTH=8. ch2 configured as CRC-16/CCITT-FALSE (poly 0x11021, init 0x0000FFFF, no reverse, xorout 0); send "123456789" -> res_crc=0x000029B1, res_ch=2.
- All 4 channels continuously valid with 2-beat packets -> grants in order 0,1,2,3,0; no requester is starved.
- res_ready held 0 for 5 cycles in RESULT -> res_valid, res_crc and res_ch stay stable; no req_ready asserted; completes on the first res_ready=1.
- resetn pulsed low mid-packet on ch1, then ch1 resends "123456789" with the CRC-32 config -> all outputs 0 during reset; result 0xCBF43926.
- With CRC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, ch3 sends one beat then stalls -> res_err=1, res_ch=3 after 16 idle cycles; the next grant goes to ch0.
